// File: rtl/afe_l2_router.sv
// ---------------------------------------------------------------------------
// afe_l2_router
// Streams AFE samples from the sample buffer to L2 channels. Each accepted
// sample is matched against a per-channel chid/subchid table (lowest channel
// wins), decimated per channel, masked, and registered onto a valid/ready
// output consumed by the L2 address generators. Flagged samples are reported
// on a separate valid/ready flag stream. Unmatched samples are counted.
//
// Optional feature macro: AFE_ROUTER_FLAG_FIFO_EN
//   defined   : flag reports are queued in a FLAG_FIFO_DEPTH-entry FIFO
//               (FLAG_FIFO_DEPTH must be a power of 2, >= 2)
//   undefined : a single flag report register, newest report wins
//
// Ports
//   clk_i, rst_i                 clock, async active-high reset
//   clr_i                        sync clear of pipeline, decim counters,
//                                flag storage, drop count, overflow flag
//   cfg_ch_*_i                   per-channel match/decimation table (packed,
//                                channel i at [i*W +: W])
//   cfg_mask_mode_i              00 raw, 01 payload+flags, 10 payload,
//                                11 sign-extended payload
//   cfg_flag_en_i/cfg_flag_mask_i flag reporting control
//   in_valid_i/in_ready_o/in_data_i          buffer-side stream
//   out_valid_o/out_ready_i/out_data_o/out_ch_o  L2-side stream
//   out_tf_o                     one-hot transfer pulse on output handshake
//   flag_valid_o/flag_ready_i/flag_data_o    flag report stream
//   drop_cnt_o                   saturating count of unmatched samples
//   flag_ovf_o                   sticky: a flag report was lost
// ---------------------------------------------------------------------------
module afe_l2_router #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned PL_WIDTH        = 16,
    parameter int unsigned CHID_LSB        = 28,
    parameter int unsigned CHID_WIDTH      = 4,
    parameter int unsigned SUBCHID_LSB     = 24,
    parameter int unsigned SUBCHID_WIDTH   = 4,
    parameter int unsigned FLAG_LSB        = 16,
    parameter int unsigned FLAG_WIDTH      = 4,
    parameter int unsigned NUM_CHS         = 8,
    parameter int unsigned DECIM_WIDTH     = 8,
    parameter int unsigned FLAG_FIFO_DEPTH = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             clr_i,
    input  logic [NUM_CHS-1:0]               cfg_ch_en_i,
    input  logic [NUM_CHS*CHID_WIDTH-1:0]    cfg_ch_chid_i,
    input  logic [NUM_CHS*SUBCHID_WIDTH-1:0] cfg_ch_subchid_i,
    input  logic [NUM_CHS-1:0]               cfg_ch_sub_en_i,
    input  logic [NUM_CHS*DECIM_WIDTH-1:0]   cfg_ch_decim_i,
    input  logic [1:0]                       cfg_mask_mode_i,
    input  logic                             cfg_flag_en_i,
    input  logic [FLAG_WIDTH-1:0]            cfg_flag_mask_i,
    input  logic                             in_valid_i,
    output logic                             in_ready_o,
    input  logic [DATA_WIDTH-1:0]            in_data_i,
    output logic                             out_valid_o,
    input  logic                             out_ready_i,
    output logic [31:0]                      out_data_o,
    output logic [$clog2(NUM_CHS)-1:0]       out_ch_o,
    output logic [NUM_CHS-1:0]               out_tf_o,
    output logic                             flag_valid_o,
    input  logic                             flag_ready_i,
    output logic [31:0]                      flag_data_o,
    output logic [15:0]                      drop_cnt_o,
    output logic                             flag_ovf_o
);

    localparam int unsigned CH_W  = $clog2(NUM_CHS);
    localparam int unsigned OUT_W = 32;

    // Build a 32-bit mask covering [lsb +: w].
    function automatic logic [OUT_W-1:0] field_mask(input int unsigned lsb, input int unsigned w);
        logic [OUT_W-1:0] m;
        m = '0;
        for (int unsigned b = 0; b < OUT_W; b++) begin
            if (b >= lsb && b < lsb + w) m[b] = 1'b1;
        end
        return m;
    endfunction

    localparam logic [OUT_W-1:0] PL_MASK   = field_mask(0, PL_WIDTH);
    localparam logic [OUT_W-1:0] FLAG_MASK = field_mask(FLAG_LSB, FLAG_WIDTH);

    // ------------------------------------------------------------------
    // Field extraction
    // ------------------------------------------------------------------
    logic [CHID_WIDTH-1:0]    s_chid;
    logic [SUBCHID_WIDTH-1:0] s_subchid;
    logic [FLAG_WIDTH-1:0]    s_flags;
    logic [OUT_W-1:0]         din32;

    assign s_chid    = in_data_i[CHID_LSB +: CHID_WIDTH];
    assign s_subchid = in_data_i[SUBCHID_LSB +: SUBCHID_WIDTH];
    assign s_flags   = in_data_i[FLAG_LSB +: FLAG_WIDTH];
    assign din32     = OUT_W'(in_data_i);

    // ------------------------------------------------------------------
    // Input handshake
    // ------------------------------------------------------------------
    logic accept;

    assign in_ready_o = !clr_i && (!out_valid_o || out_ready_i);
    assign accept     = in_valid_i && in_ready_o;

    // ------------------------------------------------------------------
    // Channel match: lowest enabled channel whose chid (and subchid, when
    // required) equals the sample's fields.
    // ------------------------------------------------------------------
    logic            match;
    logic [CH_W-1:0] match_idx;

    always_comb begin
        match     = 1'b0;
        match_idx = '0;
        for (int i = 0; i < NUM_CHS; i++) begin
            if (!match && cfg_ch_en_i[i]
                && (s_chid == cfg_ch_chid_i[i*CHID_WIDTH +: CHID_WIDTH])
                && (!cfg_ch_sub_en_i[i]
                    || (s_subchid == cfg_ch_subchid_i[i*SUBCHID_WIDTH +: SUBCHID_WIDTH]))) begin
                match     = 1'b1;
                match_idx = CH_W'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Decimation: forward when the channel counter is zero; the counter
    // walks 0..decim and wraps.
    // ------------------------------------------------------------------
    logic [DECIM_WIDTH-1:0] dcnt_q [NUM_CHS];
    logic [DECIM_WIDTH-1:0] sel_dcnt;
    logic [DECIM_WIDTH-1:0] sel_decim;
    logic                   fwd;

    assign sel_dcnt  = dcnt_q[match_idx];
    assign sel_decim = cfg_ch_decim_i[match_idx*DECIM_WIDTH +: DECIM_WIDTH];
    assign fwd       = accept && match && (sel_dcnt == '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_CHS; i++) dcnt_q[i] <= '0;
        end else if (clr_i) begin
            for (int i = 0; i < NUM_CHS; i++) dcnt_q[i] <= '0;
        end else if (accept && match) begin
            dcnt_q[match_idx] <= (sel_dcnt >= sel_decim) ? '0 : sel_dcnt + DECIM_WIDTH'(1);
        end
    end

    // ------------------------------------------------------------------
    // Payload masking
    // ------------------------------------------------------------------
    logic [OUT_W-1:0] masked;

    always_comb begin
        masked = '0;
        case (cfg_mask_mode_i)
            2'b00:   masked = din32;
            2'b01:   masked = din32 & (PL_MASK | FLAG_MASK);
            2'b10:   masked = din32 & PL_MASK;
            default: begin
                for (int unsigned b = 0; b < OUT_W; b++) begin
                    masked[b] = (b < PL_WIDTH) ? din32[b] : din32[PL_WIDTH-1];
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output register. A new sample can only be accepted when the slot is
    // empty or draining this cycle, so a forward always overwrites safely.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_ch_o    <= '0;
        end else if (clr_i) begin
            out_valid_o <= 1'b0;
        end else if (fwd) begin
            out_valid_o <= 1'b1;
            out_data_o  <= masked;
            out_ch_o    <= match_idx;
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

    // Transfer pulse to the addressed channel's address generator.
    always_comb begin
        out_tf_o = '0;
        if (out_valid_o && out_ready_i) out_tf_o[out_ch_o] = 1'b1;
    end

    // ------------------------------------------------------------------
    // Drop counter (saturating)
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            drop_cnt_o <= '0;
        end else if (clr_i) begin
            drop_cnt_o <= '0;
        end else if (accept && !match && (drop_cnt_o != 16'hFFFF)) begin
            drop_cnt_o <= drop_cnt_o + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // Flag report generation
    // ------------------------------------------------------------------
    logic        flag_hit;
    logic        flag_pop;
    logic [31:0] flag_word;

    assign flag_hit  = accept && match && cfg_flag_en_i && (|(s_flags & cfg_flag_mask_i));
    assign flag_word = {8'(s_chid), 8'(s_flags), 8'(match_idx), 8'h00};
    assign flag_pop  = flag_valid_o && flag_ready_i;

`ifdef AFE_ROUTER_FLAG_FIFO_EN
    // ------------------------------------------------------------------
    // Flag FIFO. When full, a push is kept only if a pop frees a slot in
    // the same cycle; otherwise it is lost and flag_ovf_o is set.
    // ------------------------------------------------------------------
    localparam int unsigned FAW = $clog2(FLAG_FIFO_DEPTH);

    logic [31:0]  fmem_q [FLAG_FIFO_DEPTH];
    logic [FAW-1:0] wptr_q;
    logic [FAW-1:0] rptr_q;
    logic [FAW:0]   fcnt_q;
    logic           full;
    logic           push;

    assign full         = (fcnt_q == (FAW+1)'(FLAG_FIFO_DEPTH));
    assign push         = flag_hit && (!full || flag_pop);
    assign flag_valid_o = (fcnt_q != '0);
    assign flag_data_o  = fmem_q[rptr_q];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < FLAG_FIFO_DEPTH; i++) fmem_q[i] <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            fcnt_q     <= '0;
            flag_ovf_o <= 1'b0;
        end else if (clr_i) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            fcnt_q     <= '0;
            flag_ovf_o <= 1'b0;
        end else begin
            if (push) begin
                fmem_q[wptr_q] <= flag_word;
                wptr_q         <= wptr_q + FAW'(1);
            end
            if (flag_pop) begin
                rptr_q <= rptr_q + FAW'(1);
            end
            case ({push, flag_pop})
                2'b10:   fcnt_q <= fcnt_q + (FAW+1)'(1);
                2'b01:   fcnt_q <= fcnt_q - (FAW+1)'(1);
                default: fcnt_q <= fcnt_q;
            endcase
            if (flag_hit && full && !flag_pop) begin
                flag_ovf_o <= 1'b1;
            end
        end
    end
`else
    // ------------------------------------------------------------------
    // Single flag register. A new report replaces the held one; replacing
    // a report that is not being popped this cycle marks an overflow.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            flag_valid_o <= 1'b0;
            flag_data_o  <= '0;
            flag_ovf_o   <= 1'b0;
        end else if (clr_i) begin
            flag_valid_o <= 1'b0;
            flag_data_o  <= '0;
            flag_ovf_o   <= 1'b0;
        end else if (flag_hit) begin
            flag_valid_o <= 1'b1;
            flag_data_o  <= flag_word;
            if (flag_valid_o && !flag_ready_i) begin
                flag_ovf_o <= 1'b1;
            end
        end else if (flag_pop) begin
            flag_valid_o <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_afe_l2_router.sv
// ---------------------------------------------------------------------------
// tb_afe_l2_router
// Directed, self-checking bench for afe_l2_router: a vector table for the
// streaming/masking cases plus hand-written sequences for decimation,
// backpressure, flag reporting and clear.
// ---------------------------------------------------------------------------
module tb_afe_l2_router;

    localparam int unsigned NUM_CHS = 8;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        clr_i;
    logic [7:0]  cfg_ch_en_i;
    logic [31:0] cfg_ch_chid_i;
    logic [31:0] cfg_ch_subchid_i;
    logic [7:0]  cfg_ch_sub_en_i;
    logic [63:0] cfg_ch_decim_i;
    logic [1:0]  cfg_mask_mode_i;
    logic        cfg_flag_en_i;
    logic [3:0]  cfg_flag_mask_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] in_data_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_data_o;
    logic [2:0]  out_ch_o;
    logic [7:0]  out_tf_o;
    logic        flag_valid_o;
    logic        flag_ready_i;
    logic [31:0] flag_data_o;
    logic [15:0] drop_cnt_o;
    logic        flag_ovf_o;

    afe_l2_router dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .clr_i            (clr_i),
        .cfg_ch_en_i      (cfg_ch_en_i),
        .cfg_ch_chid_i    (cfg_ch_chid_i),
        .cfg_ch_subchid_i (cfg_ch_subchid_i),
        .cfg_ch_sub_en_i  (cfg_ch_sub_en_i),
        .cfg_ch_decim_i   (cfg_ch_decim_i),
        .cfg_mask_mode_i  (cfg_mask_mode_i),
        .cfg_flag_en_i    (cfg_flag_en_i),
        .cfg_flag_mask_i  (cfg_flag_mask_i),
        .in_valid_i       (in_valid_i),
        .in_ready_o       (in_ready_o),
        .in_data_i        (in_data_i),
        .out_valid_o      (out_valid_o),
        .out_ready_i      (out_ready_i),
        .out_data_o       (out_data_o),
        .out_ch_o         (out_ch_o),
        .out_tf_o         (out_tf_o),
        .flag_valid_o     (flag_valid_o),
        .flag_ready_i     (flag_ready_i),
        .flag_data_o      (flag_data_o),
        .drop_cnt_o       (drop_cnt_o),
        .flag_ovf_o       (flag_ovf_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [1:0]  mode;
        logic        in_valid;
        logic [31:0] data;
        logic        out_ready;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic [2:0]  exp_ch;
        logic [7:0]  exp_tf;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [3:0] c, input logic [3:0] s,
                                       input logic [3:0] f, input logic [15:0] p);
        return {c, s, 4'h0, f, p};
    endfunction

    task automatic set_ch(input int idx, input logic en, input logic [3:0] chid,
                          input logic sub_en, input logic [3:0] sub, input logic [7:0] decim);
        cfg_ch_en_i[idx]                = en;
        cfg_ch_chid_i[idx*4 +: 4]       = chid;
        cfg_ch_sub_en_i[idx]            = sub_en;
        cfg_ch_subchid_i[idx*4 +: 4]    = sub;
        cfg_ch_decim_i[idx*8 +: 8]      = decim;
    endtask

    task automatic pulse_clr();
        @(negedge clk_i);
        clr_i      = 1'b1;
        in_valid_i = 1'b0;
        @(negedge clk_i);
        clr_i      = 1'b0;
    endtask

    // Watchdog: the bench never waits on DUT events, but guard anyway.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got [$];
        logic [31:0] exp_q [$];
        logic [31:0] prev_data;
        logic        prev_stall;
        int          sent;
        int          popped;
        logic [3:0]  fl [6];

        // ---------------- vector table ----------------
        for (int k = 0; k < 8; k++) begin
            vecs[k] = '{2'b00, 1'b1, mk(4'h3, 4'h0, 4'h0, 16'h0100 + 16'(k)), 1'b1,
                        1'b1, mk(4'h3, 4'h0, 4'h0, 16'h0100 + 16'(k)), 3'd3, 8'h08};
        end
        vecs[8]  = '{2'b11, 1'b1, 32'h3A05_8001, 1'b1, 1'b1, 32'hFFFF_8001, 3'd3, 8'h08};
        vecs[9]  = '{2'b10, 1'b1, 32'h3A05_8001, 1'b1, 1'b1, 32'h0000_8001, 3'd3, 8'h08};
        vecs[10] = '{2'b01, 1'b1, 32'h3A05_8001, 1'b1, 1'b1, 32'h0005_8001, 3'd3, 8'h08};
        vecs[11] = '{2'b00, 1'b1, 32'h3A05_8001, 1'b1, 1'b1, 32'h3A05_8001, 3'd3, 8'h08};
        vecs[12] = '{2'b00, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         3'd0, 8'h00};

        fl = '{4'h1, 4'h3, 4'h5, 4'h7, 4'h9, 4'hB};

        // ---------------- reset ----------------
        rst_i = 1'b1; clr_i = 1'b0;
        cfg_ch_en_i = '0; cfg_ch_chid_i = '0; cfg_ch_subchid_i = '0;
        cfg_ch_sub_en_i = '0; cfg_ch_decim_i = '0; cfg_mask_mode_i = 2'b00;
        cfg_flag_en_i = 1'b0; cfg_flag_mask_i = 4'h0;
        in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b0; flag_ready_i = 1'b0;
        #12;
        chk("rst_in_ready",   32'(in_ready_o),   32'd1);
        chk("rst_out_valid",  32'(out_valid_o),  32'd0);
        chk("rst_out_data",   out_data_o,        32'd0);
        chk("rst_flag_valid", 32'(flag_valid_o), 32'd0);
        chk("rst_flag_data",  flag_data_o,       32'd0);
        chk("rst_drop_cnt",   32'(drop_cnt_o),   32'd0);
        chk("rst_flag_ovf",   32'(flag_ovf_o),   32'd0);
        chk("rst_tf",         32'(out_tf_o),     32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // ---------------- streaming + masking table ----------------
        set_ch(3, 1'b1, 4'h3, 1'b0, 4'h0, 8'd0);
        for (int i = 0; i < 13; i++) begin
            @(negedge clk_i);
            cfg_mask_mode_i = vecs[i].mode;
            in_valid_i      = vecs[i].in_valid;
            in_data_i       = vecs[i].data;
            out_ready_i     = vecs[i].out_ready;
            #1;
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready_o), 32'd1);
            @(posedge clk_i);
            #1;
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid_o), 32'(vecs[i].exp_valid));
            chk($sformatf("v%0d_tf", i), 32'(out_tf_o), 32'(vecs[i].exp_tf));
            if (vecs[i].exp_valid) begin
                chk($sformatf("v%0d_out_data", i), out_data_o, vecs[i].exp_data);
                chk($sformatf("v%0d_out_ch", i), 32'(out_ch_o), 32'(vecs[i].exp_ch));
            end
        end
        cfg_mask_mode_i = 2'b00;

        // ---------------- first-match priority ----------------
        set_ch(1, 1'b1, 4'h7, 1'b0, 4'h0, 8'd0);
        set_ch(2, 1'b1, 4'h7, 1'b0, 4'h0, 8'd0);
        @(negedge clk_i);
        in_valid_i = 1'b1; in_data_i = mk(4'h7, 4'h0, 4'h0, 16'h0001);
        @(posedge clk_i); #1;
        chk("prio_out_ch", 32'(out_ch_o), 32'd1);
        @(negedge clk_i);
        in_valid_i = 1'b0;
        set_ch(1, 1'b0, 4'h0, 1'b0, 4'h0, 8'd0);
        set_ch(2, 1'b0, 4'h0, 1'b0, 4'h0, 8'd0);

        // ---------------- decimation + subchid + drops ----------------
        set_ch(0, 1'b1, 4'h5, 1'b1, 4'h2, 8'd2);
        pulse_clr();
        for (int k = 0; k < 12; k++) begin
            @(negedge clk_i);
            in_valid_i = 1'b1;
            in_data_i  = (k < 9) ? mk(4'h5, 4'h2, 4'h0, 16'(k)) : mk(4'h5, 4'h1, 4'h0, 16'(k));
            @(posedge clk_i); #1;
            if (out_valid_o) begin
                got.push_back(out_data_o);
                chk($sformatf("decim_ch_k%0d", k), 32'(out_ch_o), 32'd0);
            end
        end
        @(negedge clk_i);
        in_valid_i = 1'b0;
        @(posedge clk_i); #1;
        if (out_valid_o) got.push_back(out_data_o);
        chk("decim_count", 32'(got.size()), 32'd3);
        for (int j = 0; j < got.size() && j < 3; j++) begin
            chk($sformatf("decim_out%0d", j), got[j], mk(4'h5, 4'h2, 4'h0, 16'(3 * j)));
        end
        chk("decim_drop_cnt", 32'(drop_cnt_o), 32'd3);

        // ---------------- backpressure scoreboard ----------------
        sent = 0; popped = 0; prev_stall = 1'b0; prev_data = '0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk_i);
            out_ready_i = !(c >= 4 && c < 9);
            in_valid_i  = (sent < 12);
            in_data_i   = mk(4'h3, 4'h0, 4'h0, 16'h4000 + 16'(sent));
            #1;
            if (prev_stall && out_valid_o) begin
                chk($sformatf("bp_stable_c%0d", c), out_data_o, prev_data);
            end
            if (out_valid_o && !out_ready_i) begin
                chk($sformatf("bp_in_ready_c%0d", c), 32'(in_ready_o), 32'd0);
                chk($sformatf("bp_tf_idle_c%0d", c), 32'(out_tf_o), 32'd0);
            end
            if (out_valid_o && out_ready_i) begin
                chk($sformatf("bp_tf_c%0d", c), 32'(out_tf_o), 32'h08);
                if (exp_q.size() == 0) begin
                    chk($sformatf("bp_unexpected_c%0d", c), out_data_o, 32'hDEAD_BEEF);
                end else begin
                    chk($sformatf("bp_data_c%0d", c), out_data_o, exp_q.pop_front());
                    popped++;
                end
            end
            prev_stall = out_valid_o && !out_ready_i;
            prev_data  = out_data_o;
            if (in_valid_i && in_ready_o) begin
                exp_q.push_back(in_data_i);
                sent++;
            end
            @(posedge clk_i);
        end
        @(negedge clk_i);
        in_valid_i = 1'b0;
        chk("bp_sent", 32'(sent), 32'd12);
        chk("bp_popped", 32'(popped), 32'd12);
        chk("bp_leftover", 32'(exp_q.size()), 32'd0);

        // ---------------- flag reporting ----------------
        pulse_clr();
        out_ready_i = 1'b1; flag_ready_i = 1'b0;
        cfg_flag_en_i = 1'b1; cfg_flag_mask_i = 4'h1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_i);
            in_valid_i = 1'b1;
            in_data_i  = mk(4'h3, 4'h0, fl[k], 16'(k));
            @(posedge clk_i); #1;
            if (k == 0) begin
                chk("flag_first_valid", 32'(flag_valid_o), 32'd1);
                chk("flag_first_data", flag_data_o, 32'h0301_0300);
                chk("flag_first_ovf", 32'(flag_ovf_o), 32'd0);
            end
        end
        @(negedge clk_i);
        in_valid_i = 1'b0;
        #1;
        chk("flag_ovf_set", 32'(flag_ovf_o), 32'd1);
`ifdef AFE_ROUTER_FLAG_FIFO_EN
        for (int j = 0; j < 4; j++) begin
            flag_ready_i = 1'b1;
            #1;
            chk($sformatf("flag_fifo_valid%0d", j), 32'(flag_valid_o), 32'd1);
            chk($sformatf("flag_fifo_data%0d", j), flag_data_o, {8'h03, 4'h0, fl[j], 8'h03, 8'h00});
            @(negedge clk_i);
        end
`else
        flag_ready_i = 1'b1;
        #1;
        chk("flag_reg_valid", 32'(flag_valid_o), 32'd1);
        chk("flag_reg_data", flag_data_o, 32'h030B_0300);
        @(negedge clk_i);
`endif
        #1;
        chk("flag_drained", 32'(flag_valid_o), 32'd0);
        // Flags present but outside the mask raise no report.
        in_valid_i = 1'b1;
        in_data_i  = mk(4'h3, 4'h0, 4'h2, 16'h0000);
        @(posedge clk_i); #1;
        chk("flag_masked_off", 32'(flag_valid_o), 32'd0);
        chk("flag_ovf_sticky", 32'(flag_ovf_o), 32'd1);
        @(negedge clk_i);
        in_valid_i = 1'b0;

        // ---------------- clear mid-transfer ----------------
        @(negedge clk_i);
        in_valid_i = 1'b1; in_data_i = mk(4'h9, 4'h0, 4'h0, 16'h0000);
        @(posedge clk_i); #1;
        chk("clr_pre_drop", 32'(drop_cnt_o), 32'd1);
        @(negedge clk_i);
        out_ready_i = 1'b0;
        in_data_i   = mk(4'h5, 4'h2, 4'h0, 16'h0061);
        @(posedge clk_i); #1;
        chk("clr_pre_valid", 32'(out_valid_o), 32'd1);
        @(negedge clk_i);
        in_valid_i = 1'b0; clr_i = 1'b1;
        #1;
        chk("clr_in_ready", 32'(in_ready_o), 32'd0);
        @(posedge clk_i); #1;
        chk("clr_out_valid", 32'(out_valid_o), 32'd0);
        chk("clr_drop_cnt", 32'(drop_cnt_o), 32'd0);
        chk("clr_flag_ovf", 32'(flag_ovf_o), 32'd0);
        @(negedge clk_i);
        clr_i = 1'b0; out_ready_i = 1'b1;
        in_valid_i = 1'b1; in_data_i = mk(4'h5, 4'h2, 4'h0, 16'h0062);
        @(posedge clk_i); #1;
        chk("clr_post_valid", 32'(out_valid_o), 32'd1);
        chk("clr_post_data", out_data_o, mk(4'h5, 4'h2, 4'h0, 16'h0062));
        chk("clr_post_ch", 32'(out_ch_o), 32'd0);
        @(negedge clk_i);
        in_valid_i = 1'b0;
        @(negedge clk_i);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
